// File: rtl/fifo_pkg.sv
// Shared FIFO clock-crossing types, limits and gray-code helpers.
// Imported by gray_sync_decoder and the FIFO testbench scoreboards.
package fifo_pkg;

    localparam int MAX_SYNC_STAGES = 4;
    localparam int GRAY_MAX_W      = 32;

    typedef enum logic {INIT, TRACK} gsd_state_t;

    // Zero-extended inputs decode correctly at any width up to
    // GRAY_MAX_W, so callers cast in and truncate the result.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] g
    );
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer chain with synchronous active-high reset.
module sync_ff_chain #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stg[k] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                stg[k] <= stg[k-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Receive-side gray pointer synchronizer, decoder and step monitor.
// Define GRAY_STEP_CHECK_EN to build the multi-bit step detector.
module gray_sync_decoder
    import fifo_pkg::*;
#(
    parameter int SIZE        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] gray_in,
    output logic [SIZE-1:0] bin_out,
    output logic            bin_valid,
    output logic            changed,
    output logic [SIZE-1:0] delta,
    output logic            step_err
);

    localparam int CNT_W = $clog2(MAX_SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_STAGES);

    if (SYNC_STAGES < 2 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
        $error("gray_sync_decoder: SYNC_STAGES out of range");
    end

    logic [SIZE-1:0]  gs;
    logic [SIZE-1:0]  b;
    gsd_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    sync_ff_chain #(
        .WIDTH  (SIZE),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gray_in),
        .q   (gs)
    );

    assign b = SIZE'(gray2bin(GRAY_MAX_W'(gs)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // INIT waits out the synchronizer fill plus the first decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            INIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = TRACK;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            TRACK: begin
                state_nxt = TRACK;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    assign bin_valid = (state == TRACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_out <= '0;
            changed <= 1'b0;
            delta   <= '0;
        end else begin
            bin_out <= b;
            if (state == TRACK) begin
                changed <= (b != bin_out);
                delta   <= b - bin_out;
            end else begin
                changed <= 1'b0;
                delta   <= '0;
            end
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [SIZE-1:0] p;

    always_ff @(posedge clk) begin
        if (rst) begin
            p        <= '0;
            step_err <= 1'b0;
        end else begin
            p        <= gs;
            step_err <= (state == TRACK) && ($countones(gs ^ p) > 1);
        end
    end
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Self-checking bench: hand vector table, gray walk, resets and
// randomized stepping against a sample-history reference model.
module tb_gray_sync_decoder;

    localparam int SIZE = 4;
    localparam int SS   = 2;
`ifdef GRAY_STEP_CHECK_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [SIZE-1:0] gray_in;
    logic [SIZE-1:0] bin_out;
    logic            bin_valid;
    logic            changed;
    logic [SIZE-1:0] delta;
    logic            step_err;

    gray_sync_decoder #(
        .SIZE        (SIZE),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .changed   (changed),
        .delta     (delta),
        .step_err  (step_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h, expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Reference: brute-force inverse of g = b ^ (b >> 1).
    function automatic logic [3:0] dec(input logic [3:0] g);
        for (int v = 0; v < 16; v++) begin
            logic [3:0] vb;
            vb = 4'(v);
            if ((vb ^ (vb >> 1)) == g) return vb;
        end
        return 4'h0;
    endfunction

    function automatic int ones(input logic [3:0] x);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(x[i]);
        return c;
    endfunction

    // Model: every gray_in sampled since reset release, by edge number.
    logic [3:0] hist[$];
    int         n_edge = 0;
    logic [3:0] m_bin  = 0;
    logic       m_val  = 0;
    logic       m_chg  = 0;
    logic [3:0] m_dlt  = 0;
    logic       m_err  = 0;

    function automatic logic [3:0] smp(input int j);
        return (j >= 1) ? hist[j-1] : 4'h0;
    endfunction

    task automatic model_edge();
        logic [3:0] nb;
        if (rst) begin
            hist.delete();
            n_edge = 0;
            m_bin = 0; m_val = 0; m_chg = 0; m_dlt = 0; m_err = 0;
        end else begin
            n_edge++;
            hist.push_back(gray_in);
            nb = dec(smp(n_edge - SS));
            if (n_edge - 1 >= SS + 1) begin
                m_chg = (nb != m_bin);
                m_dlt = nb - m_bin;
                m_err = STEP_EN &&
                        (ones(smp(n_edge - SS) ^ smp(n_edge - SS - 1)) > 1);
            end else begin
                m_chg = 0; m_dlt = 0; m_err = 0;
            end
            m_bin = nb;
            m_val = (n_edge >= SS + 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("bin_out",   32'(bin_out),   32'(m_bin));
        chk("bin_valid", 32'(bin_valid), 32'(m_val));
        chk("changed",   32'(changed),   32'(m_chg));
        chk("delta",     32'(delta),     32'(m_dlt));
        chk("step_err",  32'(step_err),  32'(m_err));
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] gray;
        logic [3:0] bin;
        logic       val;
        logic       chg;
        logic [3:0] dlt;
        logic       err;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [3:0] g_of(input int i);
        logic [3:0] v;
        v = 4'(i);
        return v ^ (v >> 1);
    endfunction

    initial begin
        int chg_cnt;
        logic [3:0] g;

        tbl[0]  = '{1, 4'b0110, 4'h0, 0, 0, 4'h0, 0};
        tbl[1]  = '{0, 4'b0110, 4'h0, 0, 0, 4'h0, 0};
        tbl[2]  = '{0, 4'b0110, 4'h0, 0, 0, 4'h0, 0};
        tbl[3]  = '{0, 4'b0110, 4'h4, 1, 0, 4'h0, 0};
        tbl[4]  = '{0, 4'b0111, 4'h4, 1, 0, 4'h0, 0};
        tbl[5]  = '{0, 4'b0111, 4'h4, 1, 0, 4'h0, 0};
        tbl[6]  = '{0, 4'b0111, 4'h5, 1, 1, 4'h1, 0};
        tbl[7]  = '{0, 4'b0111, 4'h5, 1, 0, 4'h0, 0};
        tbl[8]  = '{0, 4'b0100, 4'h5, 1, 0, 4'h0, 0};
        tbl[9]  = '{0, 4'b0100, 4'h5, 1, 0, 4'h0, 0};
        tbl[10] = '{0, 4'b0100, 4'h7, 1, 1, 4'h2, STEP_EN};
        tbl[11] = '{0, 4'b0100, 4'h7, 1, 0, 4'h0, 0};
        tbl[12] = '{1, 4'b0100, 4'h0, 0, 0, 4'h0, 0};
        tbl[13] = '{0, 4'b0100, 4'h0, 0, 0, 4'h0, 0};
        tbl[14] = '{0, 4'b0100, 4'h0, 0, 0, 4'h0, 0};
        tbl[15] = '{0, 4'b0100, 4'h7, 1, 0, 4'h0, 0};
        tbl[16] = '{0, 4'b0100, 4'h7, 1, 0, 4'h0, 0};

        rst = 1'b1;
        gray_in = 4'b0110;
        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst;
            gray_in = tbl[i].gray;
            tick();
            chk($sformatf("tbl%0d.bin", i), 32'(bin_out), 32'(tbl[i].bin));
            chk($sformatf("tbl%0d.val", i), 32'(bin_valid), 32'(tbl[i].val));
            chk($sformatf("tbl%0d.chg", i), 32'(changed), 32'(tbl[i].chg));
            chk($sformatf("tbl%0d.dlt", i), 32'(delta), 32'(tbl[i].dlt));
            chk($sformatf("tbl%0d.err", i), 32'(step_err), 32'(tbl[i].err));
        end

        // Full gray walk then wrap back to zero.
        for (int i = 0; i <= 16; i++) begin
            gray_in = g_of(i % 16);
            chg_cnt = 0;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (changed) chg_cnt++;
            end
            chk($sformatf("walk%0d.bin", i), 32'(bin_out), 32'(i % 16));
            if (i > 0) chk($sformatf("walk%0d.pulses", i), 32'(chg_cnt), 32'd1);
        end

        // Mid-operation reset from bin_out = 1010.
        gray_in = 4'b1111;
        repeat (4) tick();
        chk("pre_rst.bin", 32'(bin_out), 32'hA);
        rst = 1'b1;
        tick();
        chk("rst.all", 32'({bin_out, bin_valid, changed, delta, step_err}), 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        chk("rst.val_early", 32'(bin_valid), 32'd0);
        tick();
        chk("rst.val_back", 32'(bin_valid), 32'd1);
        chk("rst.no_pulse", 32'(changed), 32'd0);

        // Constant input in TRACK.
        chg_cnt = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (changed || step_err || delta != 0 || bin_out != 4'hA) chg_cnt++;
        end
        chk("hold50.quiet", 32'(chg_cnt), 32'd0);

        // Randomized stepping, occasional illegal jumps and resets.
        g = gray_in;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 9) == 0)
                    g = 4'($urandom_range(0, 15));
                else
                    g = g ^ (4'b0001 << $urandom_range(0, 3));
            end
            gray_in = g;
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
